// File: rtl/ascii_tx_pkg.sv
// ascii_tx_pkg: shared types and helpers for the hex-to-ASCII UART transmitter.
//   tx_state_e      - bit-level serializer states (IDLE, START, DATA, STOP)
//   ASCII_CR/LF     - line terminator characters used when ASCII_TX_CRLF_EN is defined
//   nibble_to_ascii - hex digit to the glyph set the 7-segment display path renders
package ascii_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // B and D are lower case so they cannot be confused with 8 and 0 on a
  // seven-segment display.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
    logic [7:0] c;
    case (nib)
      4'hA:    c = 8'h41;
      4'hB:    c = 8'h62;
      4'hC:    c = 8'h43;
      4'hD:    c = 8'h64;
      4'hE:    c = 8'h45;
      4'hF:    c = 8'h46;
      default: c = 8'h30 + {4'h0, nib};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hex_to_ascii_uart_tx_if.sv
// hex_to_ascii_uart_tx_if: request/status bundle of the hex-to-ASCII UART transmitter.
//   start  - transmit request (sampled only while idle)
//   value  - 4*DIGITS bit value, most significant nibble sent first
//   busy   - sequence in progress
//   done   - one-cycle completion pulse
//   tx     - UART line, idles high
// master: the requester; slave: the transmitter.
interface hex_to_ascii_uart_tx_if #(
  parameter int DIGITS = 2
);
  logic                  start;
  logic [4*DIGITS-1:0]   value;
  logic                  busy;
  logic                  done;
  logic                  tx;

  modport master (output start, output value, input busy, input done, input tx);
  modport slave  (input start, input value, output busy, output done, output tx);
endinterface

// File: rtl/hex_to_ascii_uart_tx_byte.sv
// uart_tx_byte: 8N1 LSB-first serializer for one byte at a time.
//   clk, rst_n - clock and asynchronous active-low reset
//   load       - accept data; honoured in IDLE, or in the last cycle of STOP
//                (byte_done high) so characters run back-to-back
//   data       - byte to send
//   byte_done  - high in the last cycle of the stop bit
//   tx         - serial line (registered, reset high)
module uart_tx_byte
  import ascii_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       byte_done,
  output logic       tx
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  tx_state_e     state_reg, state_next;
  logic [BW-1:0] baud_reg, baud_next;
  logic [2:0]    bit_reg, bit_next;
  logic [7:0]    data_reg, data_next;
  logic          tx_reg, tx_next;
  logic          wrap;

  assign wrap      = (baud_reg == BAUD_LAST);
  // Kept outside the next-state process: the top's load depends on it.
  assign byte_done = (state_reg == STOP) && wrap;
  assign tx        = tx_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      data_reg  <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      data_reg  <= data_next;
      tx_reg    <= tx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    baud_next  = wrap ? '0 : baud_reg + BW'(1);
    bit_next   = bit_reg;
    data_next  = data_reg;
    tx_next    = tx_reg;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (load) begin
          state_next = START;
          data_next  = data;
          tx_next    = 1'b0;
        end
      end
      START: begin
        if (wrap) begin
          state_next = DATA;
          bit_next   = 3'd0;
          tx_next    = data_reg[0];
        end
      end
      DATA: begin
        if (wrap) begin
          if (bit_reg == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_reg + 3'd1;
            tx_next  = data_reg[bit_reg + 3'd1];
          end
        end
      end
      STOP: begin
        if (wrap) begin
          if (load) begin
            state_next = START;
            data_next  = data;
            tx_next    = 1'b0;
          end else begin
            state_next = IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: rtl/hex_to_ascii_uart_tx.sv
// hex_to_ascii_uart_tx: prints a 4*DIGITS bit value as hex ASCII over 8N1 UART.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - hex_to_ascii_uart_tx_if.slave (start, value, busy, done, tx)
// Parameters: CLKS_PER_BIT (>= 2) cycles per bit, DIGITS (1..8) characters.
// Build option: define ASCII_TX_CRLF_EN to append CR, LF after the digits.
module hex_to_ascii_uart_tx
  import ascii_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DIGITS       = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hex_to_ascii_uart_tx_if.slave  bus
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 3) + 1;
`ifdef ASCII_TX_CRLF_EN
  localparam int N_CHARS = DIGITS + 2;
`else
  localparam int N_CHARS = DIGITS;
`endif

  logic [VW-1:0] shift_reg, shift_next, shifted;
  logic [CW-1:0] count_reg, count_next, count_dec;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          load, byte_done, tx;
  logic [7:0]    load_byte;

  assign shifted   = shift_reg << 4;
  assign count_dec = count_reg - CW'(1);

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.tx   = tx;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (load_byte),
    .byte_done (byte_done),
    .tx        (tx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      count_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      count_reg <= count_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // The first character is handed to the serializer on the accept edge itself,
  // and each following one on the edge that ends the previous stop bit, so the
  // line never idles between characters.
  always_comb begin
    shift_next = shift_reg;
    count_next = count_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    load       = 1'b0;
    load_byte  = nibble_to_ascii(shift_reg[VW-1 -: 4]);
    if (!busy_reg) begin
      if (bus.start) begin
        shift_next = bus.value;
        count_next = CW'(N_CHARS);
        busy_next  = 1'b1;
        load       = 1'b1;
        load_byte  = nibble_to_ascii(bus.value[VW-1 -: 4]);
      end
    end else if (byte_done) begin
      shift_next = shifted;
      count_next = count_dec;
      if (count_dec == '0) begin
        busy_next = 1'b0;
        done_next = 1'b1;
      end else begin
        load      = 1'b1;
        load_byte = nibble_to_ascii(shifted[VW-1 -: 4]);
`ifdef ASCII_TX_CRLF_EN
        // The last two slots of the count are the line terminator.
        if (count_dec == CW'(2)) load_byte = ASCII_CR;
        else if (count_dec == CW'(1)) load_byte = ASCII_LF;
`endif
      end
    end
  end

endmodule

// File: tb/tb_hex_to_ascii_uart_tx.sv
// tb_hex_to_ascii_uart_tx: directed plus randomized checks of hex_to_ascii_uart_tx
// against a character-list / bit-stream reference model.
module tb_hex_to_ascii_uart_tx;

  localparam int C      = 4;
  localparam int DIGITS = 2;
`ifdef ASCII_TX_CRLF_EN
  localparam int NCH = DIGITS + 2;
`else
  localparam int NCH = DIGITS;
`endif
  localparam int T = NCH * 10 * C;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic exp_bits[$];
  string exp_text;
  string hex_chars;

  hex_to_ascii_uart_tx_if #(.DIGITS(DIGITS)) bus ();

  hex_to_ascii_uart_tx #(.CLKS_PER_BIT(C), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: list of characters, then one 10-bit 8N1 frame per character.
  task automatic build_exp(input logic [4*DIGITS-1:0] v);
    byte chars[$];
    byte c;
    exp_bits.delete();
    exp_text = "";
    for (int d = DIGITS - 1; d >= 0; d--) begin
      chars.push_back(hex_chars[int'(v[4*d +: 4])]);
    end
`ifdef ASCII_TX_CRLF_EN
    chars.push_back(8'h0D);
    chars.push_back(8'h0A);
`endif
    foreach (chars[i]) begin
      c = chars[i];
      exp_text = {exp_text, $sformatf("%02h ", c)};
      exp_bits.push_back(1'b0);
      for (int b = 0; b < 8; b++) exp_bits.push_back(c[b]);
      exp_bits.push_back(1'b1);
    end
  endtask

  task automatic check_cycle(input int k);
    if (k < T) begin
      check($sformatf("tx@%0d", k), 32'(bus.tx), 32'(exp_bits[k / C]));
      check($sformatf("busy@%0d", k), 32'(bus.busy), 32'd1);
      check($sformatf("done@%0d", k), 32'(bus.done), 32'd0);
    end else begin
      check($sformatf("tx_end@%0d", k), 32'(bus.tx), 32'd1);
      check($sformatf("busy_end@%0d", k), 32'(bus.busy), 32'd0);
      check($sformatf("done_end@%0d", k), 32'(bus.done), 32'd1);
    end
  endtask

  // Launches at the current negedge; returns at the negedge of cycle T.
  // pa/pb: cycles with a stray start pulse; vc: cycle where value is cleared.
  task automatic do_seq(input logic [4*DIGITS-1:0] v, input int pa, input int pb,
                        input int vc, input bit hold);
    int errs_before;
    errs_before = errors;
    build_exp(v);
    bus.value = v;
    bus.start = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= T; k++) begin
      check_cycle(k);
      bus.start = hold ? 1'b1 : ((k == pa) || (k == pb));
      if (k == vc) bus.value = '0;
      if (k < T) @(negedge clk);
    end
    $display("seq value=%h chars=%s hold=%0d new_errors=%0d", v, exp_text, hold,
             errors - errs_before);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_tx", 32'(bus.tx), 32'd1);
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_done", 32'(bus.done), 32'd0);
    end
  endtask

  initial begin
    logic [4*DIGITS-1:0] rv;
    checks    = 0;
    errors    = 0;
    hex_chars = "0123456789AbCdEF";
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.value = '0;

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Directed sequences: basic, value change after accept, stray starts.
    do_seq(8'h3B, -1, -1, -1, 1'b0);
    idle(3);
    do_seq(8'hAD, -1, -1, 5, 1'b0);
    idle(1);
    do_seq(8'h5E, 10, 50, -1, 1'b0);
    idle(2);

    // Randomized values; odd iterations restart in the done cycle.
    for (int i = 0; i < 6; i++) begin
      rv = (4*DIGITS)'($urandom);
      do_seq(rv, int'($urandom_range(1, T - 2)), int'($urandom_range(1, T - 2)),
             int'($urandom_range(0, T - 1)), 1'b0);
      if (i % 2 == 0) idle(2);
    end
    idle(1);

    // Reset in the middle of a frame.
    build_exp(8'hC7);
    bus.value = 8'hC7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 23; k++) begin
      check_cycle(k);
      @(negedge clk);
    end
    check_cycle(23);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_tx", 32'(bus.tx), 32'd1);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    $display("seq value=c7 aborted by reset at cycle 23");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    do_seq(8'h1F, -1, -1, -1, 1'b0);
    idle(2);

    // start held high: sequences repeat back-to-back one cycle after done.
    rv = (4*DIGITS)'($urandom);
    do_seq(8'h96, -1, -1, -1, 1'b1);
    do_seq(rv, -1, -1, -1, 1'b1);
    do_seq(8'h04, -1, -1, -1, 1'b0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
